// File: rtl/skinny_sbox_hpc2_seq.sv
// skinny_sbox_hpc2_seq: feeds one masked 5-share nibble plus fresh randomness to the HPC2 Skinny S-box and returns its shares.
// Define SBOX_SEQ_FRESH_EXT_EN to take randomness from fresh_in/fresh_valid instead of the internal LFSR.
module skinny_sbox_hpc2_seq #(
    parameter int SHARES = 5,
    parameter int SYNC_PERIOD = 5,
    parameter int FRESH_W = 40,
    parameter logic [FRESH_W-1:0] LFSR_SEED = 40'hA5C3_9E17_4B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*SHARES-1:0]   in_shares,
`ifdef SBOX_SEQ_FRESH_EXT_EN
    input  logic [FRESH_W-1:0]    fresh_in,
    input  logic                  fresh_valid,
`else
    input  logic                  seed_load,
    input  logic [FRESH_W-1:0]    seed,
`endif
    output logic [4*SHARES-1:0]   sb_x,
    output logic [FRESH_W-1:0]    sb_fresh,
    output logic                  sb_rst,
    input  logic                  sb_synch,
    input  logic [4*SHARES-1:0]   sb_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*SHARES-1:0]   out_shares,
    output logic                  err
);
    localparam logic [2:0] IDLE = 3'd0, ALIGN = 3'd1, WAIT = 3'd2, CAPT = 3'd3, OUT = 3'd4;
    localparam int CW = $clog2(2 * SYNC_PERIOD);
    localparam logic [CW-1:0] SYNC_MIN = CW'(SYNC_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * SYNC_PERIOD - 1);

    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [FRESH_W-1:0] fresh_next;
    logic launch;

`ifdef SBOX_SEQ_FRESH_EXT_EN
    assign in_ready = rst && state == IDLE && fresh_valid;
    assign fresh_next = fresh_in;
`else
    // Galois form of x^40 + x^38 + x^21 + x^19 + 1, shifting right
    localparam logic [FRESH_W-1:0] TAPS = FRESH_W'(40'hA0_0014_0000);
    assign in_ready = rst && state == IDLE;
    assign fresh_next = {1'b0, sb_fresh[FRESH_W-1:1]} ^ (sb_fresh[0] ? TAPS : '0);
`endif
    assign launch = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sb_x       <= '0;
            sb_fresh   <= LFSR_SEED;
            sb_rst     <= 1'b1;
            out_valid  <= 1'b0;
            out_shares <= '0;
            err        <= 1'b0;
        end else begin
            sb_rst <= 1'b0;
            case (state)
                IDLE: begin
`ifndef SBOX_SEQ_FRESH_EXT_EN
                    if (seed_load && !launch) sb_fresh <= seed == '0 ? LFSR_SEED : seed;
`endif
                    if (launch) begin
                        sb_x     <= in_shares;
                        sb_fresh <= fresh_next;
                        sb_rst   <= 1'b1;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Synch before a full gated period has elapsed is a leftover edge from before the realign
                    if (sb_synch && cnt >= SYNC_MIN) state <= CAPT;
                    else if (cnt == CNT_MAX) begin
                        err   <= 1'b1;
                        sb_x  <= '0;
                        state <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                CAPT: begin
                    out_shares <= sb_y;
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_skinny_sbox_hpc2_seq.sv
// tb_skinny_sbox_hpc2_seq: directed bench for the S-box sequencer with a transaction-timing model
// checked against every output on every falling clock edge.
module tb_skinny_sbox_hpc2_seq;
    localparam logic [39:0] SEED = 40'hA5C3_9E17_4B;
    localparam int SP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, seed_load = 1'b0, sb_synch = 1'b0, out_ready = 1'b0;
    logic [19:0] in_shares = '0, sb_y = '0;
    logic [39:0] seed = '0;
    logic in_ready, sb_rst, out_valid, err;
    logic [19:0] sb_x, out_shares;
    logic [39:0] sb_fresh;

    int total = 0, bad = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    skinny_sbox_hpc2_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
        .seed_load(seed_load), .seed(seed), .sb_x(sb_x), .sb_fresh(sb_fresh), .sb_rst(sb_rst),
        .sb_synch(sb_synch), .sb_y(sb_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_shares(out_shares), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One step of the polynomial: divide by x, folding the x^0 term back through the tap exponents
    function automatic logic [39:0] lfsr_step(input logic [39:0] v);
        int ex[4] = '{40, 38, 21, 19};
        logic [39:0] r;
        r = v >> 1;
        if (v[0]) foreach (ex[i]) r[ex[i]-1] = ~r[ex[i]-1];
        return r;
    endfunction

    // Model timed by edges since the accept edge: realign edge, a full gated period, then capture
    logic m_busy, m_cap, m_ov, m_err, m_srst;
    int m_k;
    logic [19:0] m_x, m_os;
    logic [39:0] m_fr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_cap <= 1'b0; m_ov <= 1'b0; m_err <= 1'b0; m_srst <= 1'b1;
            m_k <= 0; m_x <= '0; m_os <= '0; m_fr <= SEED;
        end else begin
            m_srst <= 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy <= 1'b1; m_k <= 1; m_cap <= 1'b0;
                    m_x <= in_shares; m_fr <= lfsr_step(m_fr); m_srst <= 1'b1;
                end else if (seed_load) m_fr <= seed == '0 ? SEED : seed;
            end else begin
                m_k <= m_k + 1;
                if (m_ov) begin
                    if (out_ready) begin m_ov <= 1'b0; m_busy <= 1'b0; end
                end else if (m_cap) begin
                    m_os <= sb_y; m_ov <= 1'b1;
                end else if (m_k >= SP + 1 && sb_synch) m_cap <= 1'b1;
                else if (m_k == 2 * SP + 1) begin
                    m_err <= 1'b1; m_x <= '0; m_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (run) begin
        chk("in_ready", in_ready, rst && !m_busy);
        chk("sb_x", sb_x, m_x);
        chk("sb_fresh", sb_fresh, m_fr);
        chk("sb_rst", sb_rst, m_srst);
        chk("out_valid", out_valid, m_ov);
        chk("out_shares", out_shares, m_os);
        chk("err", err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Launch x; synch pulses in the cycles where the DUT counter would read s_a and s_b (s_b is the real one)
    task automatic txn(input logic [19:0] x, input logic [19:0] y, input int s_a, input int s_b,
                       input int bp, input bit hold, output int lat, output logic [39:0] fr, output bit saw);
        int n = 0;
        in_shares = x;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin tick(); n++; end
        chk("accept_wait", in_ready, 1'b1);
        tick();
        fr = sb_fresh;
        in_valid = hold;
        sb_y = ~y;
        lat = 1;
        for (int c = 0; c < 14 && !out_valid; c++) begin
            sb_synch = (c == s_a + 1) || (c == s_b + 1);
            tick();
            lat++;
            if (sb_synch && c == s_b + 1) sb_y = y;
            sb_synch = 1'b0;
        end
        saw = out_valid;
        if (saw) begin
            repeat (bp) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("handshake_drop", out_valid, 1'b0);
            chk("ready_after_out", in_ready, 1'b1);
        end
    endtask

    initial begin
        int lat;
        logic [39:0] fr;
        bit saw;
        #1 rst = 1'b0;
        #1;
        chk("rst_sb_rst", sb_rst, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_fresh", sb_fresh, SEED);
        chk("rst_out_valid", out_valid, 1'b0);
        run = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("sb_rst_release", sb_rst, 1'b0);

        // Single transaction: out_valid rises in the 8th cycle counted from the accept cycle
        txn(20'h0000A, 20'h00006, -5, 4, 0, 1'b0, lat, fr, saw);
        chk("single_latency", lat, 8);
        chk("single_out", out_shares, 20'h00006);
        chk("single_x", sb_x, 20'h0000A);
        chk("fresh_step_seed", fr, 40'h52E1_CF0B_A5 ^ 40'hA0_0014_0000);

        // Back-pressure with in_valid held high, then the next input accepted immediately after
        txn(20'h12345, 20'hBEEF1, -5, 4, 10, 1'b1, lat, fr, saw);
        chk("bp_out", out_shares, 20'hBEEF1);
        txn(20'h54321, 20'h0F0F0, 1, 4, 0, 1'b0, lat, fr, saw);
        chk("stale_latency", lat, 8);
        chk("stale_out", out_shares, 20'h0F0F0);

        // Late synch at the last legal counter value
        txn(20'hFFFFF, 20'h11111, -5, 9, 0, 1'b0, lat, fr, saw);
        chk("late_out", out_shares, 20'h11111);
        chk("late_err", err, 1'b0);

        // Timeout, then a good transaction with the sticky flag still set
        txn(20'hAAAAA, 20'h22222, -5, -5, 0, 1'b0, lat, fr, saw);
        chk("timeout_no_out", saw, 1'b0);
        chk("timeout_err", err, 1'b1);
        chk("timeout_x", sb_x, 20'h0);
        txn(20'h33333, 20'h44444, -5, 4, 0, 1'b0, lat, fr, saw);
        chk("after_to_out", out_shares, 20'h44444);
        chk("after_to_err", err, 1'b1);

        // Seed handling
        seed_load = 1'b1; seed = '0;
        tick();
        chk("seed_zero", sb_fresh, SEED);
        seed = 40'h1;
        tick();
        seed_load = 1'b0;
        chk("seed_one", sb_fresh, 40'h1);
        txn(20'h0000A, 20'h00006, -5, 4, 0, 1'b0, lat, fr, saw);
        chk("seed_one_step", fr, 40'hA0_0014_0000);

        // Reset while waiting for synch
        in_shares = 20'h98765;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_x", sb_x, 20'h0);
        chk("midrst_sb_rst", sb_rst, 1'b1);
        chk("midrst_err", err, 1'b0);
        tick();
        rst = 1'b1;
        repeat (12) tick();
        chk("midrst_no_stale", out_valid, 1'b0);
        txn(20'h0C0C0, 20'h70707, -5, 4, 0, 1'b0, lat, fr, saw);
        chk("post_rst_out", out_shares, 20'h70707);
        chk("post_rst_latency", lat, 8);
        repeat (2) tick();
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
